// File: rtl/frame_buf_pingpong_ctrl.sv
// frame_buf_pingpong_ctrl
//   Ping-pong controller for one single-port data memory that holds two frame banks.
//   A pixel writer fills one bank while a pixel reader drains the other. Both share
//   the one memory port, and at most one access is granted per cycle.
//   Bank 0 spans [0, BUF_SIZE-1] and bank 1 spans [BUF_SIZE, 2*BUF_SIZE-1].
//
//   Build option FB_PINGPONG_DROP_EN:
//     The writer never stalls. When a frame completes while the other bank is still
//     full, that frame is dropped: the same bank is rewritten from its base and
//     frame_drop_cnt increments, saturating at its maximum.
//     When the option is undefined, a writer that faces a full bank stalls, and
//     frame_drop_cnt is tied to 0.
//
// Ports
//   wr_clk, reset        sole clock; synchronous active-high reset
//   wr_req/wr_data       writer request and word, held until wr_ack (comb accept)
//   rd_req               reader request, held until rd_ack (comb issue)
//   rd_data/rd_valid     read word; valid 2 cycles after its rd_ack cycle
//   mem_*                registered strobes, address and write data; mem_rd_data has
//                        1-cycle latency
//   wr_bank/rd_bank      bank being filled / drained
//   frame_avail          the reader's bank holds a complete frame
//   wr/rd_frame_done     1-cycle pulse after the last word of a frame
//   frame_drop_cnt       saturating count of dropped frames
module frame_buf_pingpong_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned BUF_SIZE   = 500
) (
  input  logic                  wr_clk,
  input  logic                  reset,
  input  logic                  wr_req,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ack,
  input  logic                  rd_req,
  output logic                  rd_ack,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  mem_wr_en,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  wr_bank,
  output logic                  rd_bank,
  output logic                  frame_avail,
  output logic                  wr_frame_done,
  output logic                  rd_frame_done,
  output logic [15:0]           frame_drop_cnt
);

  localparam int unsigned CntW = (BUF_SIZE > 1) ? $clog2(BUF_SIZE) : 1;
  localparam logic [CntW-1:0]       CntLast   = CntW'(BUF_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] Bank1Base = ADDR_WIDTH'(BUF_SIZE);

  typedef enum logic {GrantRead = 1'b0, GrantWrite = 1'b1} grant_e;

  grant_e                  last_grant_q, last_grant_d;
  logic [CntW-1:0]         wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic                    wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [1:0]              full_q, full_d;
  logic                    mem_wr_en_q, mem_wr_en_d, mem_rd_en_q, mem_rd_en_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wr_data_q, mem_wr_data_d;
  logic                    rd_valid_q, rd_valid_d;
  logic                    wr_done_q, wr_done_d, rd_done_q, rd_done_d;
  logic [15:0]             drop_cnt_q, drop_cnt_d;

  logic wr_ok, rd_ok, wr_cand, rd_cand, grant_w, grant_r, wr_last, rd_last, drop;

`ifdef FB_PINGPONG_DROP_EN
  assign wr_ok = 1'b1;
  // Completing a frame while the other bank is still unread drops this frame.
  assign drop  = wr_last & full_q[~wr_bank_q];
`else
  assign wr_ok = ~full_q[wr_bank_q];
  assign drop  = 1'b0;
`endif
  assign rd_ok = full_q[rd_bank_q];

  assign wr_cand = wr_req & wr_ok & ~reset;
  assign rd_cand = rd_req & rd_ok & ~reset;
  // Under contention the side that did not win the last handshake gets the port.
  assign grant_w = wr_cand & (~rd_cand | (last_grant_q == GrantRead));
  assign grant_r = rd_cand & ~grant_w;
  assign wr_last = (wr_cnt_q == CntLast);
  assign rd_last = (rd_cnt_q == CntLast);

  always_comb begin
    last_grant_d  = last_grant_q;
    wr_cnt_d      = wr_cnt_q;
    rd_cnt_d      = rd_cnt_q;
    wr_bank_d     = wr_bank_q;
    rd_bank_d     = rd_bank_q;
    full_d        = full_q;
    mem_wr_en_d   = 1'b0;
    mem_rd_en_d   = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    rd_valid_d    = mem_rd_en_q; // second stage covers the memory read latency
    wr_done_d     = 1'b0;
    rd_done_d     = 1'b0;
    drop_cnt_d    = drop_cnt_q;
    if (grant_w) begin
      last_grant_d  = GrantWrite;
      mem_wr_en_d   = 1'b1;
      mem_addr_d    = (wr_bank_q ? Bank1Base : '0) + ADDR_WIDTH'(wr_cnt_q);
      mem_wr_data_d = wr_data;
      if (wr_last) begin
        wr_cnt_d  = '0;
        wr_done_d = 1'b1;
        if (drop) begin
          if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
        end else begin
          full_d[wr_bank_q] = 1'b1;
          wr_bank_d         = ~wr_bank_q;
        end
      end else begin
        wr_cnt_d = wr_cnt_q + CntW'(1);
      end
    end else if (grant_r) begin
      last_grant_d = GrantRead;
      mem_rd_en_d  = 1'b1;
      mem_addr_d   = (rd_bank_q ? Bank1Base : '0) + ADDR_WIDTH'(rd_cnt_q);
      if (rd_last) begin
        rd_cnt_d          = '0;
        rd_done_d         = 1'b1;
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
      end else begin
        rd_cnt_d = rd_cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge wr_clk) begin
    if (reset) begin
      last_grant_q  <= GrantRead;
      wr_cnt_q      <= '0;
      rd_cnt_q      <= '0;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      full_q        <= '0;
      mem_wr_en_q   <= 1'b0;
      mem_rd_en_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      rd_valid_q    <= 1'b0;
      wr_done_q     <= 1'b0;
      rd_done_q     <= 1'b0;
      drop_cnt_q    <= '0;
    end else begin
      last_grant_q  <= last_grant_d;
      wr_cnt_q      <= wr_cnt_d;
      rd_cnt_q      <= rd_cnt_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      full_q        <= full_d;
      mem_wr_en_q   <= mem_wr_en_d;
      mem_rd_en_q   <= mem_rd_en_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      rd_valid_q    <= rd_valid_d;
      wr_done_q     <= wr_done_d;
      rd_done_q     <= rd_done_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  assign wr_ack        = grant_w;
  assign rd_ack        = grant_r;
  assign rd_data       = mem_rd_data;
  assign rd_valid      = rd_valid_q;
  assign mem_wr_en     = mem_wr_en_q;
  assign mem_rd_en     = mem_rd_en_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wr_data   = mem_wr_data_q;
  assign wr_bank       = wr_bank_q;
  assign rd_bank       = rd_bank_q;
  assign frame_avail   = full_q[rd_bank_q];
  assign wr_frame_done = wr_done_q;
  assign rd_frame_done = rd_done_q;
`ifdef FB_PINGPONG_DROP_EN
  assign frame_drop_cnt = drop_cnt_q;
`else
  assign frame_drop_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_frame_buf_pingpong_ctrl.sv
// Directed bench for frame_buf_pingpong_ctrl with BUF_SIZE=4, ADDR_WIDTH=3.
// A behavioural memory with 1-cycle read latency sits on the mem_* port.
module tb_frame_buf_pingpong_ctrl;
  localparam int DW = 32;
  localparam int AW = 3;

  logic          wr_clk = 1'b0;
  logic          reset, wr_req, rd_req;
  logic [DW-1:0] wr_data;
  logic          wr_ack, rd_ack, rd_valid, mem_wr_en, mem_rd_en;
  logic [DW-1:0] rd_data, mem_wr_data;
  logic [DW-1:0] mem_rd_data = '0;
  logic [AW-1:0] mem_addr;
  logic          wr_bank, rd_bank, frame_avail, wr_frame_done, rd_frame_done;
  logic [15:0]   frame_drop_cnt;

  logic [DW-1:0] mem [8];
  logic [DW-1:0] a_words [4] = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
  int n_tests = 0;
  int n_fail  = 0;

  frame_buf_pingpong_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BUF_SIZE(4)) dut (
    .wr_clk(wr_clk), .reset(reset), .wr_req(wr_req), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_ack(rd_ack), .rd_data(rd_data), .rd_valid(rd_valid),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data), .wr_bank(wr_bank),
    .rd_bank(rd_bank), .frame_avail(frame_avail), .wr_frame_done(wr_frame_done),
    .rd_frame_done(rd_frame_done), .frame_drop_cnt(frame_drop_cnt)
  );

  always #5 wr_clk = ~wr_clk;

  always @(posedge wr_clk) begin
    if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
    if (mem_rd_en) mem_rd_data <= mem[mem_addr];
  end

  task automatic tick();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1; wr_req = 1'b0; rd_req = 1'b0; wr_data = '0;
    repeat (cycles) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(3);
    n_tests++;
    if ({wr_ack, rd_ack, rd_valid, mem_wr_en, mem_rd_en, wr_frame_done, rd_frame_done} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b want 0",
               {wr_ack, rd_ack, rd_valid, mem_wr_en, mem_rd_en, wr_frame_done, rd_frame_done});
    end
    n_tests++;
    if ({mem_addr, mem_wr_data, frame_drop_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_regs: addr %0h wdata %0h drops %0d want 0", mem_addr, mem_wr_data,
               frame_drop_cnt);
    end
    n_tests++;
    if ({wr_bank, rd_bank, frame_avail} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_banks: got %b want 000", {wr_bank, rd_bank, frame_avail});
    end
  endtask

  task automatic test_write_frame();
    wr_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_data = a_words[i];
      #1;
      n_tests++;
      if (wr_ack !== 1'b1) begin n_fail++; $display("FAIL wr_ack[%0d]: got %b want 1", i, wr_ack); end
      tick();
      n_tests++;
      if ({mem_wr_en, mem_addr, mem_wr_data} !== {1'b1, 3'(i), a_words[i]}) begin
        n_fail++;
        $display("FAIL wr_port[%0d]: en %b addr %0d data %0h want 1 %0d %0h", i, mem_wr_en,
                 mem_addr, mem_wr_data, i, a_words[i]);
      end
      n_tests++;
      if (wr_frame_done !== (i == 3)) begin
        n_fail++;
        $display("FAIL wr_frame_done[%0d]: got %b want %b", i, wr_frame_done, i == 3);
      end
    end
    wr_req = 1'b0;
    n_tests++;
    if ({wr_bank, rd_bank, frame_avail} !== 3'b101) begin
      n_fail++;
      $display("FAIL wr_end_banks: got %b want 101", {wr_bank, rd_bank, frame_avail});
    end
    tick();
    n_tests++;
    if ({wr_frame_done, mem_wr_en} !== 2'b00) begin
      n_fail++;
      $display("FAIL wr_idle: done/en %b want 00", {wr_frame_done, mem_wr_en});
    end
  endtask

  task automatic test_read_frame();
    for (int t = 1; t <= 6; t++) begin
      logic exp_valid;
      rd_req = (t <= 4);
      #1;
      n_tests++;
      if (rd_ack !== (t <= 4)) begin
        n_fail++;
        $display("FAIL rd_ack[%0d]: got %b want %b", t, rd_ack, t <= 4);
      end
      tick();
      if (t <= 4) begin
        n_tests++;
        if ({mem_rd_en, mem_addr} !== {1'b1, 3'(t - 1)}) begin
          n_fail++;
          $display("FAIL rd_port[%0d]: en %b addr %0d want 1 %0d", t, mem_rd_en, mem_addr, t - 1);
        end
      end
      exp_valid = (t >= 2) && (t <= 5);
      n_tests++;
      if (rd_valid !== exp_valid) begin
        n_fail++;
        $display("FAIL rd_valid[%0d]: got %b want %b", t, rd_valid, exp_valid);
      end
      if (exp_valid) begin
        n_tests++;
        if (rd_data !== a_words[t-2]) begin
          n_fail++;
          $display("FAIL rd_data[%0d]: got %0h want %0h", t, rd_data, a_words[t-2]);
        end
      end
      if (t == 4) begin
        rd_req = 1'b0;
        n_tests++;
        if ({rd_frame_done, rd_bank, frame_avail} !== 3'b110) begin
          n_fail++;
          $display("FAIL rd_end: done/bank/avail %b want 110",
                   {rd_frame_done, rd_bank, frame_avail});
        end
      end
    end
  endtask

  // Bank0 full, one lone read leaves last grant = READ, so the writer takes the first
  // contended slot and the two sides then alternate.
  task automatic test_alternate();
    logic exp_w [7]   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    int   exp_addr [7] = '{4, 1, 5, 2, 6, 3, 7};
    int   wk = 0;
    do_reset(1);
    wr_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_data = 32'hB0 + i;
      tick();
    end
    wr_req = 1'b0;
    rd_req = 1'b1;
    #1;
    n_tests++;
    if (rd_ack !== 1'b1) begin n_fail++; $display("FAIL alt_lone_rd: got %b want 1", rd_ack); end
    tick();
    rd_req = 1'b0;
    wr_req = 1'b1;
    rd_req = 1'b1;
    for (int k = 0; k < 7; k++) begin
      wr_data = 32'hC0 + wk;
      #1;
      n_tests++;
      if ({wr_ack, rd_ack} !== {exp_w[k], ~exp_w[k]}) begin
        n_fail++;
        $display("FAIL alt_ack[%0d]: w/r %b want %b", k, {wr_ack, rd_ack}, {exp_w[k], ~exp_w[k]});
      end
      tick();
      n_tests++;
      if ({mem_wr_en, mem_rd_en, mem_addr} !== {exp_w[k], ~exp_w[k], 3'(exp_addr[k])}) begin
        n_fail++;
        $display("FAIL alt_port[%0d]: w/r %b addr %0d want %b %0d", k, {mem_wr_en, mem_rd_en},
                 mem_addr, {exp_w[k], ~exp_w[k]}, exp_addr[k]);
      end
      if (exp_w[k]) wk++;
    end
    wr_req = 1'b0;
    rd_req = 1'b0;
    n_tests++;
    if ({wr_bank, rd_bank, frame_avail} !== 3'b011) begin
      n_fail++;
      $display("FAIL alt_end: w/r/avail %b want 011", {wr_bank, rd_bank, frame_avail});
    end
  endtask

  task automatic test_writer_only();
    do_reset(1);
    wr_req = 1'b1;
`ifdef FB_PINGPONG_DROP_EN
    for (int i = 0; i < 10; i++) begin
      wr_data = 32'hD0 + i;
      #1;
      n_tests++;
      if (wr_ack !== 1'b1) begin n_fail++; $display("FAIL drop_ack[%0d]: got %b want 1", i, wr_ack); end
      tick();
      if (i >= 8) begin
        n_tests++;
        if (mem_addr !== 3'(i - 4)) begin
          n_fail++;
          $display("FAIL drop_addr[%0d]: got %0d want %0d", i, mem_addr, i - 4);
        end
      end
      if (i == 7) begin
        n_tests++;
        if (wr_frame_done !== 1'b1) begin
          n_fail++;
          $display("FAIL drop_done: got %b want 1", wr_frame_done);
        end
      end
    end
    wr_req = 1'b0;
    n_tests++;
    if ({frame_drop_cnt, wr_bank, frame_avail} !== {16'd1, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL drop_end: cnt %0d bank %b avail %b want 1 1 1", frame_drop_cnt, wr_bank,
               frame_avail);
    end
`else
    for (int i = 0; i < 12; i++) begin
      wr_data = 32'hD0 + i;
      #1;
      n_tests++;
      if (wr_ack !== (i < 8)) begin
        n_fail++;
        $display("FAIL stall_ack[%0d]: got %b want %b", i, wr_ack, i < 8);
      end
      tick();
    end
    wr_req = 1'b0;
    n_tests++;
    if ({mem_wr_en, wr_bank, frame_avail, frame_drop_cnt} !== {1'b0, 1'b0, 1'b1, 16'd0}) begin
      n_fail++;
      $display("FAIL stall_end: en %b bank %b avail %b drops %0d want 0 0 1 0", mem_wr_en,
               wr_bank, frame_avail, frame_drop_cnt);
    end
`endif
  endtask

  task automatic test_reset_mid_frame();
    do_reset(1);
    wr_req = 1'b1;
    wr_data = 32'hE0;
    tick();
    wr_data = 32'hE1;
    tick();
    wr_req = 1'b0;
    do_reset(1);
    n_tests++;
    if ({frame_avail, wr_bank, rd_bank, mem_wr_en} !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_rst_state: got %b want 0000", {frame_avail, wr_bank, rd_bank, mem_wr_en});
    end
    wr_req = 1'b1;
    wr_data = 32'hE5;
    #1;
    n_tests++;
    if (wr_ack !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ack: got %b want 1", wr_ack); end
    tick();
    wr_req = 1'b0;
    n_tests++;
    if ({mem_wr_en, mem_addr, mem_wr_data} !== {1'b1, 3'd0, 32'hE5}) begin
      n_fail++;
      $display("FAIL mid_rst_addr: en %b addr %0d data %0h want 1 0 e5", mem_wr_en, mem_addr,
               mem_wr_data);
    end
  endtask

  initial begin
    reset = 1'b1; wr_req = 1'b0; rd_req = 1'b0; wr_data = '0;
    test_reset();
    test_write_frame();
    test_read_frame();
    test_alternate();
    test_writer_only();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
